// File: rtl/elevator_pkg.sv
// Shared elevator types: landing count, floor index, plant FSM states.
// Used by the car plant and the controller so both agree on sensor widths.
package elevator_pkg;

    localparam int FLOORS  = 5;
    localparam int FLOOR_W = $clog2(FLOORS);

    typedef logic [FLOOR_W-1:0] floor_t;
    typedef logic [FLOORS-1:0]  snsr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_MOVING,
        ST_COAST,
        ST_FAULT
    } plant_state_t;

    function automatic snsr_t onehot(input floor_t f);
        return snsr_t'(1) << f;
    endfunction

endpackage

// File: rtl/elevator_car_plant_if.sv
// Controller <-> car plant bundle: motor commands one way, sensors/status back.
// master = controller side, slave = plant side.
interface elevator_car_plant_if;
    import elevator_pkg::*;

    logic   motor;
    logic   direction;
    snsr_t  in_snsr;
    snsr_t  out_snsr;
    floor_t floor;
    logic   aligned;
    logic   moving;
    logic   fault;

    modport master (
        output motor, direction,
        input  in_snsr, out_snsr, floor, aligned, moving, fault
    );

    modport slave (
        input  motor, direction,
        output in_snsr, out_snsr, floor, aligned, moving, fault
    );

endinterface

// File: rtl/elevator_pos_counter.sv
// Sub-floor car position counter (floor, sub) with up/down tick and end-stop detect.
// Latency: position updates on the edge after tick_req; next position is exposed combinationally.
// Backpressure: none; a tick into an end-stop is suppressed and flagged via end_stop.
module elevator_pos_counter
    import elevator_pkg::*;
#(
    parameter  int TICKS_PER_FLOOR = 4,
    parameter  int INIT_FLOOR      = 0,
    localparam int SUB_W           = $clog2(TICKS_PER_FLOOR)
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   tick_req,
    input  logic   tick_up,
    output floor_t floor,
    output logic   aligned,
    output floor_t next_floor,
    output logic   next_aligned,
    output logic   end_stop
);

    localparam logic [SUB_W-1:0] SUB_MAX   = SUB_W'(TICKS_PER_FLOOR - 1);
    localparam floor_t           TOP_FLOOR = floor_t'(FLOORS - 1);

    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] next_sub;
    logic             wrap;

    assign aligned      = (sub == '0);
    assign next_aligned = (next_sub == '0);

    always_comb begin
        end_stop   = aligned && (tick_up ? (floor == TOP_FLOOR) : (floor == '0));
        wrap       = tick_up ? (sub == SUB_MAX) : aligned;
        next_floor = floor;
        next_sub   = sub;
        if (tick_req && !end_stop) begin
            if (tick_up) begin
                if (wrap) begin
                    next_floor = floor + 1'b1;
                    next_sub   = '0;
                end else begin
                    next_sub   = sub + 1'b1;
                end
            end else begin
                if (wrap) begin
                    next_floor = floor - 1'b1;
                    next_sub   = SUB_MAX;
                end else begin
                    next_sub   = sub - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            floor <= floor_t'(INIT_FLOOR);
            sub   <= '0;
        end else begin
            floor <= next_floor;
            sub   <= next_sub;
        end
    end

endmodule

// File: rtl/elevator_car_plant.sv
// Elevator car/shaft plant: turns motor/direction commands into floor sensor vectors.
// Latency: first tick START_DELAY edges after motor is first sampled; sensors registered from next position.
// Backpressure: none; over-travel is suppressed and latches a sticky fault until reset.
module elevator_car_plant
    import elevator_pkg::*;
#(
    parameter int TICKS_PER_FLOOR = 4,
    parameter int START_DELAY     = 2,
    parameter int INIT_FLOOR      = 0
) (
    input logic                 clk,
    input logic                 reset,
    elevator_car_plant_if.slave bus
);

    localparam int               CNT_W    = $clog2(START_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_DELAY);

    plant_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             coast_dir;
    logic             tick_req;
    logic             tick_up;
    snsr_t            in_snsr_q;
    snsr_t            out_snsr_q;
    logic             moving_q;
    logic             fault_q;

    floor_t floor;
    floor_t next_floor;
    logic   aligned;
    logic   next_aligned;
    logic   end_stop;

    elevator_pos_counter #(
        .TICKS_PER_FLOOR (TICKS_PER_FLOOR),
        .INIT_FLOOR      (INIT_FLOOR)
    ) u_pos (
        .clk          (clk),
        .reset        (reset),
        .tick_req     (tick_req),
        .tick_up      (tick_up),
        .floor        (floor),
        .aligned      (aligned),
        .next_floor   (next_floor),
        .next_aligned (next_aligned),
        .end_stop     (end_stop)
    );

    assign cnt_nxt = cnt + 1'b1;

    // Coasting keeps the direction latched at entry unless the motor is re-engaged.
    always_comb begin
        tick_req = 1'b0;
        tick_up  = bus.direction;
        unique case (state)
            ST_ACCEL:  tick_req = bus.motor && (cnt_nxt == CNT_LAST);
            ST_MOVING: tick_req = bus.motor || !aligned;
            ST_COAST: begin
                tick_req = 1'b1;
                if (!bus.motor) tick_up = coast_dir;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            coast_dir  <= 1'b0;
            in_snsr_q  <= onehot(floor_t'(INIT_FLOOR));
            out_snsr_q <= '0;
            moving_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            out_snsr_q <= in_snsr_q;
            in_snsr_q  <= next_aligned ? onehot(next_floor) : '0;
            if (tick_req && end_stop) begin
                state    <= ST_FAULT;
                fault_q  <= 1'b1;
                moving_q <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (bus.motor) begin
                            state <= ST_ACCEL;
                            cnt   <= '0;
                        end
                    end
                    ST_ACCEL: begin
                        if (!bus.motor) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt_nxt;
                            if (cnt_nxt == CNT_LAST) begin
                                state    <= ST_MOVING;
                                moving_q <= 1'b1;
                            end
                        end
                    end
                    // A coast that lands on this very tick stops straight away.
                    ST_MOVING: begin
                        if (!bus.motor) begin
                            if (next_aligned) begin
                                state    <= ST_IDLE;
                                moving_q <= 1'b0;
                            end else begin
                                state     <= ST_COAST;
                                coast_dir <= bus.direction;
                            end
                        end
                    end
                    ST_COAST: begin
                        if (bus.motor) begin
                            state <= ST_MOVING;
                        end else if (next_aligned) begin
                            state    <= ST_IDLE;
                            moving_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_snsr  = in_snsr_q;
    assign bus.out_snsr = out_snsr_q;
    assign bus.floor    = floor;
    assign bus.aligned  = aligned;
    assign bus.moving   = moving_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_elevator_car_plant.sv
// Scripted drive of the car plant with hand-derived expectations queued per cycle
// and compared one cycle later, plus reset-value checks.
module tb_elevator_car_plant;
    import elevator_pkg::*;

    logic clk = 1'b0;
    logic reset;

    elevator_car_plant_if bus();

    elevator_car_plant #(
        .TICKS_PER_FLOOR (4),
        .START_DELAY     (2),
        .INIT_FLOOR      (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         fl;
        logic [4:0] ins;
        logic [4:0] outs;
        logic       mv;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        expect_eq({tag, "/floor"},    32'(bus.floor),    0);
        expect_eq({tag, "/in_snsr"},  32'(bus.in_snsr),  32'b00001);
        expect_eq({tag, "/out_snsr"}, 32'(bus.out_snsr), 0);
        expect_eq({tag, "/aligned"},  32'(bus.aligned),  1);
        expect_eq({tag, "/moving"},   32'(bus.moving),   0);
        expect_eq({tag, "/fault"},    32'(bus.fault),    0);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        expect_eq({e.tag, "/floor"},    32'(bus.floor),    32'(e.fl));
        expect_eq({e.tag, "/in_snsr"},  32'(bus.in_snsr),  32'(e.ins));
        expect_eq({e.tag, "/out_snsr"}, 32'(bus.out_snsr), 32'(e.outs));
        expect_eq({e.tag, "/aligned"},  32'(bus.aligned),  32'(e.ins != 5'b0));
        expect_eq({e.tag, "/moving"},   32'(bus.moving),   32'(e.mv));
        expect_eq({e.tag, "/fault"},    32'(bus.fault),    32'(e.flt));
    endtask

    // Drive one cycle of motor/direction, queue the expected post-edge outputs, then compare.
    task automatic cyc(input string tag, input logic m, input logic d, input int fl,
                       input logic [4:0] ins, input logic [4:0] outs, input logic mv, input logic flt);
        exp_t e;
        bus.motor     = m;
        bus.direction = d;
        e.tag  = tag;
        e.fl   = fl;
        e.ins  = ins;
        e.outs = outs;
        e.mv   = mv;
        e.flt  = flt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [4:0] one;
        logic [4:0] ins_e;
        logic [4:0] prev;
        one           = 5'b00001;
        reset         = 1'b1;
        bus.motor     = 1'b0;
        bus.direction = 1'b0;
        #2;
        check_reset("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("por_hold");
        @(negedge clk);
        reset = 1'b0;

        cyc("rel",  0, 0, 0, 5'b00001, 5'b00001, 0, 0);
        // Motor dropped during ACCEL: back to IDLE, no movement.
        cyc("ab1",  1, 1, 0, 5'b00001, 5'b00001, 0, 0);
        cyc("ab2",  0, 1, 0, 5'b00001, 5'b00001, 0, 0);
        cyc("ab3",  0, 1, 0, 5'b00001, 5'b00001, 0, 0);

        cyc("up1",  1, 1, 0, 5'b00001, 5'b00001, 0, 0);
        cyc("up2",  1, 1, 0, 5'b00001, 5'b00001, 0, 0);
        cyc("up3",  1, 1, 0, 5'b00000, 5'b00001, 1, 0);
        cyc("up4",  1, 1, 0, 5'b00000, 5'b00000, 1, 0);
        cyc("up5",  1, 1, 0, 5'b00000, 5'b00000, 1, 0);
        cyc("up6",  1, 1, 1, 5'b00010, 5'b00000, 1, 0);
        cyc("up7",  1, 1, 1, 5'b00000, 5'b00010, 1, 0);
        cyc("up8",  1, 1, 1, 5'b00000, 5'b00000, 1, 0);

        cyc("cst1", 0, 1, 1, 5'b00000, 5'b00000, 1, 0);
        cyc("cst2", 0, 1, 2, 5'b00100, 5'b00000, 0, 0);
        cyc("cst3", 0, 0, 2, 5'b00100, 5'b00100, 0, 0);

        cyc("rv1",  1, 1, 2, 5'b00100, 5'b00100, 0, 0);
        cyc("rv2",  1, 1, 2, 5'b00100, 5'b00100, 0, 0);
        cyc("rv3",  1, 1, 2, 5'b00000, 5'b00100, 1, 0);
        cyc("rv4",  1, 1, 2, 5'b00000, 5'b00000, 1, 0);
        cyc("rv5",  1, 0, 2, 5'b00000, 5'b00000, 1, 0);
        cyc("rv6",  1, 0, 2, 5'b00100, 5'b00000, 1, 0);
        cyc("rv7",  0, 0, 2, 5'b00100, 5'b00100, 0, 0);

        // Coast must keep the latched up direction after direction flips.
        cyc("cl1",  1, 1, 2, 5'b00100, 5'b00100, 0, 0);
        cyc("cl2",  1, 1, 2, 5'b00100, 5'b00100, 0, 0);
        cyc("cl3",  1, 1, 2, 5'b00000, 5'b00100, 1, 0);
        cyc("cl4",  1, 1, 2, 5'b00000, 5'b00000, 1, 0);
        cyc("cl5",  0, 1, 2, 5'b00000, 5'b00000, 1, 0);
        cyc("cl6",  0, 0, 3, 5'b01000, 5'b00000, 0, 0);
        cyc("cl7",  0, 0, 3, 5'b01000, 5'b01000, 0, 0);

        cyc("t1",   1, 1, 3, 5'b01000, 5'b01000, 0, 0);
        cyc("t2",   1, 1, 3, 5'b01000, 5'b01000, 0, 0);
        cyc("t3",   1, 1, 3, 5'b00000, 5'b01000, 1, 0);
        cyc("t4",   1, 1, 3, 5'b00000, 5'b00000, 1, 0);
        cyc("t5",   1, 1, 3, 5'b00000, 5'b00000, 1, 0);
        cyc("t6",   1, 1, 4, 5'b10000, 5'b00000, 1, 0);
        cyc("t7",   0, 1, 4, 5'b10000, 5'b10000, 0, 0);

        cyc("f1",   1, 1, 4, 5'b10000, 5'b10000, 0, 0);
        cyc("f2",   1, 1, 4, 5'b10000, 5'b10000, 0, 0);
        cyc("f3",   1, 1, 4, 5'b10000, 5'b10000, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("fh%0d", i), i[0], i[1], 4, 5'b10000, 5'b10000, 0, 1);
        end

        reset = 1'b1;
        #2;
        check_reset("flt_rst");
        @(negedge clk);
        reset = 1'b0;

        cyc("mm_a1", 1, 1, 0, 5'b00001, 5'b00001, 0, 0);
        cyc("mm_a2", 1, 1, 0, 5'b00001, 5'b00001, 0, 0);
        prev = 5'b00001;
        for (int k = 1; k <= 13; k++) begin
            ins_e = ((k % 4) == 0) ? (one << (k / 4)) : 5'b00000;
            cyc($sformatf("mm%0d", k), 1, 1, k / 4, ins_e, prev, 1, 0);
            prev = ins_e;
        end
        reset = 1'b1;
        #2;
        check_reset("mid_rst");
        @(posedge clk);
        #1;
        check_reset("mid_rst_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
